// File: rtl/mat_mult_pkg.sv
// Shared types and constants for the time-shared 2x2 matrix multiplier.
package mat_mult_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      MUL   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int N        = 2;
   localparam int NUM_ELEM = N * N;
   localparam int NUM_PROD = N * N * N;
   localparam int RES_W    = 16;
   localparam int RES_BITS = NUM_ELEM * RES_W;

   // Element e = i*N + j; R00 occupies the most significant slot of res_data.
   localparam int R00_IDX = 0;
   localparam int R01_IDX = 1;
   localparam int R10_IDX = 2;
   localparam int R11_IDX = 3;

   // Tag that rides alongside a product through the multiplier pipeline.
   typedef struct packed {
      logic vld;
      logic i;
      logic j;
   } tag_t;

   // LSB position of element e inside the packed result word.
   function automatic int elem_lsb(input int e);
      return (NUM_ELEM - 1 - e) * RES_W;
   endfunction

endpackage

// File: rtl/p_multiplier.sv
// Unsigned multiplier with LAT register stages from operands to product.
module p_multiplier #(
   parameter int WIDTH = 8,
   parameter int LAT   = 1
) (
   input  logic               clk,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product
);

   logic [2*WIDTH-1:0] stg [LAT];

   // Register the raw product, then delay it through the remaining stages.
   always_ff @(posedge clk) begin
      stg[0] <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      for (int s = 1; s < LAT; s++) begin
         stg[s] <= stg[s-1];
      end
   end

   assign product = stg[LAT-1];

endmodule

// File: rtl/mat_mult_seq.sv
// 2x2 matrix multiply sequenced through a single pipelined multiplier.
//
// state | meaning
// LOAD  | accept eight operand beats A00..A11, B00..B11
// MUL   | issue one product per cycle, n = 0..7
// DRAIN | let the last in-flight products reach the accumulators
// DONE  | present packed result until res_ready
module mat_mult_seq #(
   parameter int WIDTH   = 8,
   parameter int MUL_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [63:0]      res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy
);

   import mat_mult_pkg::*;

   state_t             state, state_nxt;
   logic [2:0]         load_cnt;
   logic [2:0]         issue_cnt;
   logic [WIDTH-1:0]   ops [NUM_PROD];
   tag_t               tag_pipe [MUL_LAT];
   tag_t               tag_out;
   logic [RES_W-1:0]   acc     [NUM_ELEM];
   logic [RES_W-1:0]   acc_nxt [NUM_ELEM];
   logic [RES_BITS-1:0] res_pack;
   logic [RES_BITS-1:0] res_q;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mul_a, mul_b;
   logic               mul_i, mul_j, mul_k;
   logic               beat_acc, last_beat, pipe_pending;

   assign beat_acc  = in_valid && in_ready;
   assign last_beat = beat_acc && (load_cnt == 3'(NUM_PROD - 1));

   // Operands are stored in beat order: A at 0..3, B at 4..7, row-major.
   assign mul_i   = issue_cnt[2];
   assign mul_j   = issue_cnt[1];
   assign mul_k   = issue_cnt[0];
   assign mul_a   = ops[{1'b0, mul_i, mul_k}];
   assign mul_b   = ops[{1'b1, mul_k, mul_j}];
   assign tag_out = tag_pipe[MUL_LAT-1];

   p_multiplier #(
      .WIDTH (WIDTH),
      .LAT   (MUL_LAT)
   ) u_mul (
      .clk     (clk),
      .a       (mul_a),
      .b       (mul_b),
      .product (prod)
   );

   // Any tag still behind the output stage means products remain after this cycle.
   always_comb begin
      pipe_pending = 1'b0;
      for (int s = 0; s < MUL_LAT - 1; s++) begin
         pipe_pending = pipe_pending | tag_pipe[s].vld;
      end
   end

   // Accumulator update for the product emerging this cycle, plus its packed view.
   always_comb begin
      for (int e = 0; e < NUM_ELEM; e++) begin
         acc_nxt[e] = acc[e];
      end
      if (tag_out.vld) begin
         acc_nxt[{tag_out.i, tag_out.j}] = acc[{tag_out.i, tag_out.j}] + prod[RES_W-1:0];
      end
      res_pack = '0;
      for (int e = 0; e < NUM_ELEM; e++) begin
         res_pack[elem_lsb(e) +: RES_W] = acc_nxt[e];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= LOAD;
      else       state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (last_beat)             state_nxt = MUL;
         MUL:     if (issue_cnt == 3'd7)     state_nxt = DRAIN;
         DRAIN:   if (!pipe_pending)         state_nxt = DONE;
         DONE:    if (res_ready)             state_nxt = LOAD;
         default:                            state_nxt = LOAD;
      endcase
   end

   // Handshake and status outputs decoded from state.
   always_comb begin
      in_ready  = (state == LOAD);
      res_valid = (state == DONE);
      busy      = (state != LOAD);
   end

   // Operand capture, issue counting, tag pipe and accumulation.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_cnt  <= '0;
         issue_cnt <= '0;
         res_q     <= '0;
         for (int b = 0; b < NUM_PROD; b++) ops[b] <= '0;
         for (int s = 0; s < MUL_LAT; s++)  tag_pipe[s] <= '0;
         for (int e = 0; e < NUM_ELEM; e++) acc[e] <= '0;
      end else begin
         if (beat_acc) begin
            ops[load_cnt] <= in_data;
            load_cnt      <= load_cnt + 3'd1;
         end
         if (state == MUL) issue_cnt <= issue_cnt + 3'd1;

         tag_pipe[0] <= '{vld: (state == MUL), i: mul_i, j: mul_j};
         for (int s = 1; s < MUL_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];

         for (int e = 0; e < NUM_ELEM; e++) begin
            acc[e] <= last_beat ? '0 : acc_nxt[e];
         end

         // Capture the final sums as DONE is entered so the result survives the next job's load.
         if (state == DRAIN && !pipe_pending) res_q <= res_pack;
      end
   end

   assign res_data = res_q;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq: table vectors, corner sequences, random jobs.
module tb_mat_mult_seq;

   localparam int MUL_LAT = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] res_data;
   logic        res_valid;
   logic        res_ready;
   logic        busy;

   int total = 0;
   int bad   = 0;

   mat_mult_seq #(.WIDTH(8), .MUL_LAT(MUL_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] ops;   // A00 in [63:56] .. B11 in [7:0]
      logic [63:0] exp;
      logic        gaps;
      logic [3:0]  hold;
      logic        junk;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Plain matrix product of the two operand matrices, each element mod 2^16.
   function automatic logic [63:0] model(input logic [63:0] ops);
      int a [2][2];
      int b [2][2];
      int s;
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 2; k++) begin
            a[i][k] = int'(ops[63 - 8*(2*i+k) -: 8]);
            b[i][k] = int'(ops[31 - 8*(2*i+k) -: 8]);
         end
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            s = 0;
            for (int k = 0; k < 2; k++) s = s + a[i][k] * b[k][j];
            r[63 - 16*(2*i+j) -: 16] = s[15:0];
         end
      return r;
   endfunction

   task automatic send_ops(input logic [63:0] ops, input bit gaps);
      for (int b = 0; b < 8; b++) begin
         if (gaps && (b % 2 == 1)) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = ops[63 - 8*b -: 8];
         if (b == 0) chk("first_beat_ready", {63'd0, in_ready}, 64'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic do_job(input logic [63:0] ops, input logic [63:0] exp,
                         input bit gaps, input int hold, input bit junk);
      int lat;
      bit ok_ready, ok_stable;
      logic [63:0] snap;
      send_ops(ops, gaps);
      lat = 0;
      ok_ready = 1'b1;
      while (res_valid !== 1'b1 && lat < 100) begin
         if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
         end
         if (in_ready !== 1'b0 || busy !== 1'b1) ok_ready = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(8 + MUL_LAT));
      chk("no_ready_while_busy", {63'd0, ok_ready}, 64'd1);
      chk("result", res_data, exp);
      snap = res_data;
      ok_stable = 1'b1;
      res_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
         end
         @(posedge clk); #1;
         if (res_valid !== 1'b1 || res_data !== snap || in_ready !== 1'b0) ok_stable = 1'b0;
      end
      if (hold > 0) chk("hold_stable", {63'd0, ok_stable}, 64'd1);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      in_valid  = 1'b0;
      chk("post_hs_valid", {63'd0, res_valid}, 64'd0);
      chk("post_hs_ready", {63'd0, in_ready}, 64'd1);
      chk("post_hs_busy",  {63'd0, busy}, 64'd0);
      chk("post_hs_data",  res_data, exp);
   endtask

   initial begin
      vec_t vecs [5];
      logic [63:0] rops;

      vecs[0] = '{ops: 64'h0102_0304_0506_0708, exp: 64'h0013_0016_002B_0032, gaps: 1'b0, hold: 4'd0, junk: 1'b0};
      vecs[1] = '{ops: 64'hFFFF_FFFF_FFFF_FFFF, exp: 64'hFC02_FC02_FC02_FC02, gaps: 1'b0, hold: 4'd0, junk: 1'b0};
      vecs[2] = '{ops: 64'h0A0B_0C0D_0102_0304, exp: 64'h002B_0040_0033_004C, gaps: 1'b1, hold: 4'd5, junk: 1'b0};
      vecs[3] = '{ops: 64'h0102_0304_0506_0708, exp: 64'h0013_0016_002B_0032, gaps: 1'b0, hold: 4'd3, junk: 1'b1};
      vecs[4] = '{ops: 64'h0100_0001_0908_0706, exp: 64'h0009_0008_0007_0006, gaps: 1'b0, hold: 4'd0, junk: 1'b1};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
      chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
      chk("rst_busy",      {63'd0, busy}, 64'd0);
      chk("rst_res_data",  res_data, 64'd0);
      reset = 1'b0;

      for (int v = 0; v < 5; v++) begin
         do_job(vecs[v].ops, vecs[v].exp, vecs[v].gaps, int'(vecs[v].hold), vecs[v].junk);
      end

      // Abort a job at issue n=3, then check a fresh job carries no residue.
      send_ops(64'h0505_0505_0505_0505, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      chk("mid_mul_busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_in_ready",  {63'd0, in_ready}, 64'd1);
      chk("abort_res_valid", {63'd0, res_valid}, 64'd0);
      chk("abort_busy",      {63'd0, busy}, 64'd0);
      chk("abort_res_data",  res_data, 64'd0);
      do_job(64'h0203_0405_0607_0809, model(64'h0203_0405_0607_0809), 1'b0, 0, 1'b0);

      // Back-to-back: the second job's first beat arrives right after the handshake.
      do_job(64'h1122_3344_5566_7788, model(64'h1122_3344_5566_7788), 1'b0, 0, 1'b0);
      do_job(64'h0908_0706_0504_0302, model(64'h0908_0706_0504_0302), 1'b0, 0, 1'b0);

      for (int r = 0; r < 15; r++) begin
         rops = {$urandom, $urandom};
         do_job(rops, model(rops), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
